// File: rtl/lms_sync_fifo.sv
// Single-clock parametrised FIFO for LMS/audio sample streams, with water level,
// almost-full/empty thresholds, sticky error flags and optional first-word-fall-through.
module lms_sync_fifo #(
   parameter int DATA_WIDTH       = 16,
   parameter int DEPTH_WIDTH      = 10,
   parameter int ALMOST_FULL_NUM  = 1020,
   parameter int ALMOST_EMPTY_NUM = 4,
   parameter int FWFT             = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [DATA_WIDTH-1:0]  wr_data,
   output logic                   wr_full,
   output logic                   almost_full,
   input  logic                   rd_en,
   output logic [DATA_WIDTH-1:0]  rd_data,
   output logic                   rd_empty,
   output logic                   almost_empty,
   output logic [DEPTH_WIDTH:0]   water_level,
   input  logic                   err_clr,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int                   DEPTH    = 2**DEPTH_WIDTH;
   localparam logic [DEPTH_WIDTH:0] LVL_FULL = (DEPTH_WIDTH+1)'(DEPTH);
   localparam logic [DEPTH_WIDTH:0] LVL_AF   = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
   localparam logic [DEPTH_WIDTH:0] LVL_AE   = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

   if (ALMOST_FULL_NUM >= DEPTH || ALMOST_EMPTY_NUM == 0) begin : g_bad_param
      $error("lms_sync_fifo: ALMOST_FULL_NUM must be < 2**DEPTH_WIDTH and ALMOST_EMPTY_NUM >= 1");
   end

   logic [DATA_WIDTH-1:0]  mem [DEPTH];
   logic [DEPTH_WIDTH:0]   wr_ptr;
   logic [DEPTH_WIDTH:0]   rd_ptr;
   logic [DEPTH_WIDTH:0]   level_next;
   logic                   wr_acc;
   logic                   rd_acc;
   logic                   ram_empty;
   logic                   ram_rd;
   logic                   empty_next;

   always_comb begin
      wr_acc     = wr_en & ~wr_full;
      rd_acc     = rd_en & ~rd_empty;
      ram_empty  = (wr_ptr == rd_ptr);
      level_next = water_level + (DEPTH_WIDTH+1)'(wr_acc) - (DEPTH_WIDTH+1)'(rd_acc);
   end

   if (FWFT != 0) begin : g_fwft
      // out_valid marks the prefetch register as holding the head word; it is
      // refilled from RAM whenever it is empty or being popped.
      logic out_valid;
      logic out_valid_next;

      assign ram_rd         = ~ram_empty & (~out_valid | rd_acc);
      assign out_valid_next = ram_rd | (out_valid & ~rd_acc);
      assign empty_next     = ~out_valid_next;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) out_valid <= 1'b0;
         else     out_valid <= out_valid_next;
      end
   end else begin : g_std
      assign ram_rd     = rd_acc & ~ram_empty;
      assign empty_next = (level_next == '0);
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr[DEPTH_WIDTH-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         water_level  <= '0;
         rd_data      <= '0;
         wr_full      <= 1'b0;
         almost_full  <= 1'b0;
         rd_empty     <= 1'b1;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (ram_rd) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr[DEPTH_WIDTH-1:0]];
         end
         water_level  <= level_next;
         wr_full      <= (level_next == LVL_FULL);
         almost_full  <= (level_next >= LVL_AF);
         rd_empty     <= empty_next;
         almost_empty <= (level_next <= LVL_AE);
         // a new error wins over a simultaneous clear
         overflow     <= (wr_en & wr_full)  | (overflow  & ~err_clr);
         underflow    <= (rd_en & rd_empty) | (underflow & ~err_clr);
      end
   end

endmodule
